// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// Single 1-bit full-adder cell; the serial adder reuses it once per clock.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | ((x ^ y) & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder, LSB first, one bit per clock through one fa_cell.
// Optional subtract input enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_next;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so the incoming carry is ignored when sub is set.
    assign op_b   = sub ? ~b : b;
    assign op_cin = sub ? 1'b1 : cin;
`else
    assign op_b   = b;
    assign op_cin = cin;
`endif

    assign last_bit = (cnt == CW'(WIDTH - 1));

    fa_cell u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // The final sum bit lands on top of the WIDTH-1 bits already collected.
    assign acc_next = {fa_s, acc};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values;
    // the operand shifters are cleared too, which keeps reset state fully deterministic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= op_b;
            carry <= op_cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_co;
            acc   <= acc_next[WIDTH-1:1];
            if (last_bit) begin
                sum  <= acc_next;
                cout <= fa_co;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on accepted start.
REQ-006 b  input  WIDTH  operand B; captured on accepted start.
REQ-007 cin  input  1  carry-in; captured on accepted start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse: result valid.
REQ-010 sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-011 cout  output  1  carry-out of bit WIDTH-1; held with sum.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, using exactly one 1-bit full-adder cell, LSB first, one bit per clock.
REQ-013 States SHALL be IDLE, RUN, DONE; encoding comes from the shared package.
REQ-014 IDLE: start=1 at edge k captures a, b, cin into shift/carry registers, clears bit counter, sets busy=1, goes to RUN.
REQ-015 RUN: each edge feeds operand bit i and the carry register into the cell, shifts the sum bit into the result MSB, stores carry-out, and increments the counter.
REQ-016 Edge k+WIDTH processes bit WIDTH-1, loads sum/cout outputs, sets done=1, busy=0, and goes to DONE.
REQ-017 Latency: done high in the cycle following edge k+WIDTH; busy high for exactly WIDTH cycles.
REQ-018 DONE SHALL last one cycle, clear done and return to IDLE unconditionally; start during DONE is ignored.
REQ-019 start while busy=1 SHALL be ignored; captured operands are unaffected by input changes after capture.
REQ-020 sum/cout SHALL NOT change during RUN; internal partial results stay in private registers.
REQ-021 Bit counter width SHALL be $clog2(WIDTH); no wrap occurs, since RUN exits at count WIDTH-1.
REQ-022 Carry-out of bit WIDTH-1 is cout; there is no overflow or saturation.

Reset
REQ-023 rst_n=0 at any edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, and carry register=0.
REQ-024 Reset during RUN SHALL abort the operation with no done pulse; start in the first cycle after reset release is accepted.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN, when defined, adds input sub (1 bit, captured with the operands). sub=1 computes a - b as a + ~b + 1, with cin ignored; cout=1 means no borrow.
REQ-026 Without SERIAL_ADDER_SUB_EN, the sub port SHALL NOT exist and behaviour is addition only.

Structure
REQ-027 A shared package serial_adder_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-028 The 1-bit adder SHALL be a sub-module fa_cell (sum = x^y^ci, co = x&y | (x^y)&ci), instantiated once.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x3C, cin=0, start at edge k -> busy for 8 cycles, done after edge k+8, sum=0x96, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-031 start held high continuously with a=0x01, b=0x01 -> one operation per 10 cycles (IDLE, 8 RUN, DONE); start pulses during RUN/DONE produce no extra done.
REQ-032 rst_n=0 at the 4th RUN cycle -> no done pulse, sum=0, cout=0; a new start with a=0x03, b=0x04 -> sum=0x07.
REQ-033 With SERIAL_ADDER_SUB_EN, sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; a=0x01, b=0x02 -> sum=0xFF, cout=0.
